// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle sequencer for the RV32I datapath.
// Moves each instruction through FETCH, DECODE, EXEC, MEM and WB. It handshakes
// with variable-latency instruction and data memories, and it drives the
// IR/PC/register-file enables and branch evaluation. An illegal opcode or a
// memory wait that runs out of time puts it into a sticky TRAP state.
//
// Optional build macro: MULTICYCLE_CTRL_PERF_EN adds a retired-instruction
// counter. When the macro is not defined, retiredCount reads as zero.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   opcode            instruction[6:0] from the instruction register
//   imemReady         instruction memory returned data this cycle
//   dmemReady         data memory access complete this cycle
//   imemReq           instruction fetch request
//   irWrite           load instruction register (pulse)
//   dmemRead/Write    data memory read / write request
//   branchEval        evaluate branch condition and select PC source
//   regWrite          register file write enable
//   pcWrite           PC update enable; also the retire strobe (pulse)
//   state             FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   trap, trapCause   sticky fault flag; 1 illegal, 2 imem timeout, 3 dmem timeout
//   retiredCount      retired instruction count (optional feature)
module multicycle_ctrl #(
  parameter logic [6:0]  INST_R         = 7'b0110011,
  parameter logic [6:0]  INST_I_LD      = 7'b0000011,
  parameter logic [6:0]  INST_I_IMM     = 7'b0010011,
  parameter logic [6:0]  INST_S         = 7'b0100011,
  parameter logic [6:0]  INST_B         = 7'b1100011,
  parameter logic [6:0]  INST_J         = 7'b1101111,
  parameter logic [6:0]  INST_U         = 7'b0110111,
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter int unsigned TIMER_BITWIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        imemReady,
  input  logic        dmemReady,
  output logic        imemReq,
  output logic        irWrite,
  output logic        dmemRead,
  output logic        dmemWrite,
  output logic        branchEval,
  output logic        regWrite,
  output logic        pcWrite,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trapCause,
  output logic [31:0] retiredCount
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam bit                      TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TIMER_BITWIDTH-1:0] TO_LAST = TIMER_BITWIDTH'(MEM_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [1:0]                cause_q, cause_d;
  logic [6:0]                opc_q, opc_d;
  logic [TIMER_BITWIDTH-1:0] wait_q, wait_d;

  logic imem_req_c, ir_write_c, dmem_read_c, dmem_write_c;
  logic branch_eval_c, reg_write_c, pc_write_c, trap_c;
  logic legal;

  assign legal = (opcode == INST_R)     || (opcode == INST_I_LD) ||
                 (opcode == INST_I_IMM) || (opcode == INST_S)    ||
                 (opcode == INST_B)     || (opcode == INST_J)    ||
                 (opcode == INST_U);

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    opc_d         = opc_q;
    wait_d        = wait_q;
    imem_req_c    = 1'b0;
    ir_write_c    = 1'b0;
    dmem_read_c   = 1'b0;
    dmem_write_c  = 1'b0;
    branch_eval_c = 1'b0;
    reg_write_c   = 1'b0;
    pc_write_c    = 1'b0;
    trap_c        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        // A ready on the final allowed wait cycle takes precedence over the timeout.
        if (imemReady) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (TO_EN && wait_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_q + TIMER_BITWIDTH'(1);
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        if (opc_q == INST_B) begin
          branch_eval_c = 1'b1;
          pc_write_c    = 1'b1;
          state_d       = S_FETCH;
          wait_d        = '0;
        end else if (opc_q == INST_I_LD || opc_q == INST_S) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_read_c  = (opc_q == INST_I_LD);
        dmem_write_c = (opc_q != INST_I_LD);
        if (dmemReady) begin
          if (opc_q == INST_I_LD) begin
            state_d = S_WB;
          end else begin
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
            wait_d     = '0;
          end
        end else if (TO_EN && wait_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_q + TIMER_BITWIDTH'(1);
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_d     = S_FETCH;
        wait_d      = '0;
      end
      S_TRAP: begin
        trap_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= '0;
      opc_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      opc_q   <= opc_d;
      wait_q  <= wait_d;
    end
  end

  // Reset masks every output combinationally, so a pending request drops in the same cycle.
  assign imemReq    = rst ? 1'b0 : imem_req_c;
  assign irWrite    = rst ? 1'b0 : ir_write_c;
  assign dmemRead   = rst ? 1'b0 : dmem_read_c;
  assign dmemWrite  = rst ? 1'b0 : dmem_write_c;
  assign branchEval = rst ? 1'b0 : branch_eval_c;
  assign regWrite   = rst ? 1'b0 : reg_write_c;
  assign pcWrite    = rst ? 1'b0 : pc_write_c;
  assign trap       = rst ? 1'b0 : trap_c;
  assign state      = rst ? '0 : state_q;
  assign trapCause  = rst ? '0 : cause_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired_q;

  // pcWrite is never raised in TRAP, which keeps the count frozen there.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (pc_write_c) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retiredCount = rst ? '0 : retired_q;
`else
  assign retiredCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl, built with a 4-cycle memory timeout.
// Each instruction is expanded from its class into the per-cycle output
// sequence it should produce. Unused inputs and the opcode outside DECODE are
// driven with random values.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_U   = 7'b0110111;
  localparam int PW_BIT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        imemReady, dmemReady;
  logic        imemReq, irWrite, dmemRead, dmemWrite, branchEval, regWrite, pcWrite, trap;
  logic [2:0]  state;
  logic [1:0]  trapCause;
  logic [31:0] retiredCount;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ret_m = '0;
  logic [12:0] obs;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq), .irWrite(irWrite), .dmemRead(dmemRead), .dmemWrite(dmemWrite),
    .branchEval(branchEval), .regWrite(regWrite), .pcWrite(pcWrite), .state(state),
    .trap(trap), .trapCause(trapCause), .retiredCount(retiredCount)
  );

  always #5 clk = ~clk;

  assign obs = {imemReq, irWrite, dmemRead, dmemWrite, branchEval, regWrite, pcWrite,
                trap, state, trapCause};

  function automatic logic [12:0] ev(int st, bit imr, bit irw, bit drd, bit dwr, bit be,
                                     bit rw, bit pw, bit tr, int cause);
    return {imr, irw, drd, dwr, be, rw, pw, tr, 3'(st), 2'(cause)};
  endfunction

  function automatic logic rn();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // 0 illegal, 1 ALU-like (R/IMM/U/J), 2 load, 3 store, 4 branch
  function automatic int cls(logic [6:0] op);
    if (op == OP_LD) return 2;
    if (op == OP_S) return 3;
    if (op == OP_B) return 4;
    if (op == OP_R || op == OP_IMM || op == OP_U || op == OP_J) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_ret(logic r);
`ifdef MULTICYCLE_CTRL_PERF_EN
    return r ? 32'd0 : ret_m;
`else
    return 32'd0;
`endif
  endfunction

  // One clock cycle: drive the inputs just after the falling edge, check, then move to the next falling edge.
  task automatic cyc(input logic r, input logic [6:0] op, input logic ir, input logic dr,
                     input logic [12:0] exp, input string tag);
    logic [31:0] er;
    rst = r; opcode = op; imemReady = ir; dmemReady = dr;
    #1;
    er = exp_ret(r);
    checks++;
    assert ({obs, retiredCount} === {exp, er}) else begin
      failures++;
      $error("FAIL %s: observed=%h ret=%0d expected=%h ret=%0d", tag, obs, retiredCount, exp, er);
    end
    if (r) ret_m = '0;
    else if (exp[PW_BIT]) ret_m = ret_m + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, rop(), rn(), rn(), '0, "reset_outputs");
  endtask

  // Full instruction; a wait of 4 or more cycles is expected to reach the timeout trap.
  task automatic do_instr(input logic [6:0] op, input int iw, input int dw);
    int k;
    k = cls(op);
    for (int i = 0; i < ((iw > 4) ? 4 : iw); i++)
      cyc(1'b0, rop(), 1'b0, rn(), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
    if (iw >= 4) begin
      repeat (2) cyc(1'b0, rop(), 1'b0, rn(), ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 2), "imem_timeout_trap");
      return;
    end
    cyc(1'b0, rop(), 1'b1, rn(), ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "fetch_ready");
    cyc(1'b0, op, rn(), rn(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    if (k == 0) begin
      repeat (3) cyc(1'b0, rop(), rn(), rn(), ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 1), "illegal_trap");
      return;
    end
    cyc(1'b0, rop(), rn(), rn(), ev(2, 0, 0, 0, 0, k == 4, 0, k == 4, 0, 0), "exec");
    if (k == 4) return;
    if (k == 2 || k == 3) begin
      for (int i = 0; i < ((dw > 4) ? 4 : dw); i++)
        cyc(1'b0, rop(), rn(), 1'b0, ev(3, 0, 0, k == 2, k == 3, 0, 0, 0, 0, 0), "mem_wait");
      if (dw >= 4) begin
        repeat (2) cyc(1'b0, rop(), rn(), rn(), ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 3), "dmem_timeout_trap");
        return;
      end
      cyc(1'b0, rop(), rn(), 1'b1, ev(3, 0, 0, k == 2, k == 3, 0, 0, k == 3, 0, 0), "mem_ready");
      if (k == 3) return;
    end
    cyc(1'b0, rop(), rn(), rn(), ev(4, 0, 0, 0, 0, 0, 1, 1, 0, 0), "writeback");
  endtask

  initial begin
    logic [6:0] legal_ops [7];
    logic [6:0] bad;
    legal_ops = '{OP_R, OP_LD, OP_IMM, OP_S, OP_B, OP_J, OP_U};
    rst = 1'b1; opcode = '0; imemReady = 1'b0; dmemReady = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed instructions with zero wait, then a load held for three wait cycles
    do_instr(OP_R, 0, 0);
    do_instr(OP_LD, 0, 3);
    do_instr(OP_S, 0, 0);
    do_instr(OP_B, 0, 0);

    // Illegal opcode, followed by recovery through reset
    do_instr(7'b1111111, 0, 0);
    do_reset();
    cyc(1'b0, rop(), 1'b0, rn(), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "post_trap_fetch");

    // Instruction fetch timeout, and a ready that arrives on the last allowed cycle
    do_reset();
    do_instr(OP_IMM, 4, 0);
    do_reset();
    do_instr(OP_R, 3, 0);

    // Data memory timeout on a store; a 3-cycle wait on a load must still complete
    do_instr(OP_S, 1, 4);
    do_reset();
    do_instr(OP_LD, 2, 3);

    // Reset asserted in the middle of a load wait
    cyc(1'b0, rop(), 1'b1, rn(), ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "rw_fetch");
    cyc(1'b0, OP_LD, rn(), rn(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_decode");
    cyc(1'b0, rop(), rn(), rn(), ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_exec");
    cyc(1'b0, rop(), rn(), 1'b0, ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 0), "rw_mem_wait");
    cyc(1'b1, rop(), rn(), 1'b0, '0, "rw_reset_drops_req");
    cyc(1'b0, rop(), 1'b0, rn(), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rw_refetch");
    do_instr(OP_J, 0, 0);

    // Random legal instructions with random memory latencies
    for (int n = 0; n < 60; n++)
      do_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3));

    // Random illegal opcodes
    for (int n = 0; n < 4; n++) begin
      do bad = rop(); while (cls(bad) != 0);
      do_instr(bad, $urandom_range(0, 3), 0);
      do_reset();
    end
    do_instr(OP_U, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath; replaces single-cycle operation so instruction and data memories with variable latency can share the existing decode/ALU/register-file path.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives memory request/ready handshakes, IR/PC/register-file write enables and branch evaluation.
- Detects illegal opcodes and memory timeouts and enters a sticky TRAP state.

Parameters:
INST_R, 7'b0110011, R-type opcode
INST_I_LD, 7'b0000011, load opcode
INST_I_IMM, 7'b0010011, ALU-immediate opcode
INST_S, 7'b0100011, store opcode
INST_B, 7'b1100011, branch opcode
INST_J, 7'b1101111, JAL opcode
INST_U, 7'b0110111, LUI opcode
MEM_TIMEOUT, 16, maximum wait cycles per memory request; 0 disables the timeout
TIMER_BITWIDTH, 16, width of the wait counter; must satisfy MEM_TIMEOUT < 2^TIMER_BITWIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active high
opcode  input  7  instruction[6:0] from the instruction register
imemReady  input  1  instruction memory has returned data this cycle
dmemReady  input  1  data memory access is complete this cycle
imemReq  output  1  instruction fetch request
irWrite  output  1  load the instruction register
dmemRead  output  1  data memory read request
dmemWrite  output  1  data memory write request
branchEval  output  1  datapath evaluates the branch condition and selects the PC source
regWrite  output  1  register file write enable
pcWrite  output  1  PC update enable; also the retire strobe
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
trap  output  1  sticky fault flag
trapCause  output  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
retiredCount  output  32  retired instruction count (optional feature only)

Behaviour:
- Reset (takes priority over everything):
  - rst=1 at a clock edge: state<=FETCH, trapCause<=0, latched opcode<=0, wait counter<=0, retiredCount<=0.
  - While rst=1, every output is forced to 0.
- Output decoding:
  - All control outputs are decoded combinationally from the state register, the latched opcode and the ready inputs.
  - irWrite and pcWrite are single-cycle pulses.
- FETCH:
  - imemReq=1 until imemReady.
  - On the cycle imemReady=1: irWrite=1, next state DECODE.
- DECODE (1 cycle):
  - Latch opcode.
  - Opcode matches one of the seven parameters: go to EXEC.
  - Otherwise: go to TRAP with trapCause=1.
- EXEC (1 cycle):
  - R, IMM, U, J: go to WB.
  - LD, S: go to MEM.
  - B: branchEval=1 and pcWrite=1, go to FETCH.
- MEM:
  - LD: dmemRead=1. S: dmemWrite=1. The request is held until dmemReady.
  - On ready, LD: go to WB.
  - On ready, S: pcWrite=1, go to FETCH.
- WB (1 cycle): regWrite=1, pcWrite=1, go to FETCH.
- TRAP:
  - trap=1; all other control outputs are 0.
  - Stays in TRAP until rst.
- Latency with zero-wait memories (cycles, including FETCH): B 3, S 4, R/IMM/U/J 4, LD 5.
  - Each wait cycle on a memory adds one cycle.
- Timeout:
  - The wait counter clears on entering FETCH or MEM and increments each cycle the relevant ready is low.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with ready still low, go to TRAP with cause 2 (FETCH) or 3 (MEM).
  - A ready arriving on that same cycle wins: normal transition, no trap.
- Ready inputs are ignored in states that do not issue the matching request.
- The latched opcode is held constant from DECODE until the next DECODE.
- rst asserted mid-wait: the request drops the same cycle (outputs forced to 0); FETCH restarts after rst falls.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: retiredCount increments by 1 on each cycle pcWrite=1 (wraps at 2^32), is reset to 0 by rst and is frozen in TRAP.
- Undefined: retiredCount is tied to 32'd0 and no counter register is built.

Test Plan:
- Reset then R-type opcode 0110011, imemReady=1 every cycle -> states 0,1,2,4,0; regWrite and pcWrite high only in the WB cycle; 4 cycles per instruction.
- Load 0000011 with dmemReady low 3 cycles -> dmemRead held for 4 cycles, then WB; 8 cycles total; with the feature enabled, retiredCount=1.
- Store 0100011 then branch 1100011 -> store: dmemWrite, then pcWrite on the ready cycle, no regWrite; branch: branchEval=pcWrite=1 in EXEC, 3 cycles.
- Opcode 1111111 -> TRAP after DECODE, trap=1, trapCause=1, all enables 0 until rst; after rst, state=0 and trapCause=0.
- MEM_TIMEOUT=4, imemReady held low -> TRAP, trapCause=2, 4 cycles after entering FETCH; repeat with imemReady=1 on the 4th cycle -> irWrite=1, no trap.
- rst pulsed during a MEM wait -> dmemRead drops the same cycle; the next instruction fetch begins with state=0.
